// File: rtl/canny_frame_loader.sv
// canny_frame_loader: buffers one IMG_DIM x IMG_DIM frame of quantized pixels and replays it as a LANES-wide burst.
// Ports: clk/reset; in_valid/in_ready/in_sof/in_pixel input stream; burst_req/frame_ready handshake;
//        pixel_out0..4 lanes, load_end on the last beat, sync_err pulse on framing errors. Assumes LANES >= 2.
module canny_frame_loader #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 5,
  parameter int IMG_DIM = 20,
  parameter int LANES   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [IN_W-1:0]  in_pixel,
  input  logic             burst_req,
  output logic             frame_ready,
  output logic [OUT_W-1:0] pixel_out0,
  output logic [OUT_W-1:0] pixel_out1,
  output logic [OUT_W-1:0] pixel_out2,
  output logic [OUT_W-1:0] pixel_out3,
  output logic [OUT_W-1:0] pixel_out4,
  output logic             load_end,
  output logic             sync_err
);

  localparam int NPIX   = IMG_DIM * IMG_DIM;
  localparam int NWORDS = NPIX / LANES;
  localparam int CW     = $clog2(NPIX + 1);
  localparam int AW     = $clog2(NWORDS + 1);
  localparam int LW     = $clog2(LANES + 1);
  localparam int WW     = LANES * OUT_W;
  localparam int SH     = IN_W - OUT_W;
  localparam logic [IN_W:0] RND = (IN_W+1)'(2 ** (SH - 1));

  typedef enum logic [1:0] {FILL, FULL, BURST} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [LW-1:0]    r_lane;
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_rd_addr;
  logic [WW-1:0]    r_stage;
  logic [WW-1:0]    r_dout;
  logic             r_in_ready;
  logic             r_frame_ready;
  logic             r_load_end;
  logic             r_sync_err;
  logic [WW-1:0]    r_mem [NWORDS];

  // Rounded quantization carried one bit wider so the top bit flags overflow.
  logic [OUT_W:0]   w_qw;
  logic [OUT_W-1:0] w_q;
  assign w_qw = (OUT_W+1)'(({1'b0, in_pixel} + RND) >> SH);
  assign w_q  = w_qw[OUT_W] ? {OUT_W{1'b1}} : w_qw[OUT_W-1:0];

  // in_ready is only high in FILL, so a transfer implies FILL.
  logic          w_xfer, w_start, w_orphan, w_accept, w_take, w_wr_en, w_last;
  logic [LW-1:0] w_lane;
  logic [AW-1:0] w_waddr;
  logic [WW-1:0] w_word;
  assign w_xfer   = in_valid & r_in_ready;
  assign w_start  = w_xfer & in_sof;
  assign w_orphan = w_xfer & ~in_sof & (r_cnt == '0);
  assign w_accept = w_xfer & ~in_sof & (r_cnt != '0);
  assign w_take   = w_start | w_accept;
  // A start-of-frame pixel always lands in lane 0 of word 0, whatever was staged.
  assign w_lane   = w_start ? '0 : r_lane;
  assign w_waddr  = w_start ? '0 : r_waddr;
  assign w_wr_en  = w_take & (w_lane == LW'(LANES - 1));
  assign w_word   = {w_q, r_stage[(LANES-1)*OUT_W-1:0]};
  assign w_last   = w_accept & (r_cnt == CW'(NPIX - 1));

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_waddr] <= w_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FILL;
      r_cnt         <= '0;
      r_lane        <= '0;
      r_waddr       <= '0;
      r_rd_addr     <= '0;
      r_stage       <= '0;
      r_dout        <= '0;
      r_in_ready    <= 1'b1;
      r_frame_ready <= 1'b0;
      r_load_end    <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_sync_err <= (w_start & (r_cnt != '0)) | w_orphan;
      case (r_state)
        FILL: begin
          if (w_start) r_cnt <= CW'(1);
          else if (w_accept) r_cnt <= r_cnt + CW'(1);
          if (w_take) begin
            if (w_wr_en) begin
              r_lane  <= '0;
              r_waddr <= w_waddr + AW'(1);
            end else begin
              for (int j = 0; j < LANES; j++)
                if (w_lane == LW'(j)) r_stage[j*OUT_W +: OUT_W] <= w_q;
              r_lane  <= w_lane + LW'(1);
              r_waddr <= w_waddr;
            end
          end
          if (w_last) begin
            r_state       <= FULL;
            r_in_ready    <= 1'b0;
            r_frame_ready <= 1'b1;
          end
        end
        FULL: begin
          // Beat 0 is launched on the same edge that samples the request.
          if (burst_req) begin
            r_state       <= BURST;
            r_frame_ready <= 1'b0;
            r_dout        <= r_mem[0];
            r_rd_addr     <= AW'(1);
            r_load_end    <= (NWORDS == 1);
          end
        end
        BURST: begin
          if (r_load_end) begin
            r_state    <= FILL;
            r_dout     <= '0;
            r_load_end <= 1'b0;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_waddr    <= '0;
            r_in_ready <= 1'b1;
          end else begin
            r_dout     <= r_mem[r_rd_addr];
            r_rd_addr  <= r_rd_addr + AW'(1);
            r_load_end <= (r_rd_addr == AW'(NWORDS - 1));
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign frame_ready = r_frame_ready;
  assign load_end    = r_load_end;
  assign sync_err    = r_sync_err;
  assign pixel_out0  = r_dout[0*OUT_W +: OUT_W];
  assign pixel_out1  = r_dout[1*OUT_W +: OUT_W];
  assign pixel_out2  = r_dout[2*OUT_W +: OUT_W];
  assign pixel_out3  = r_dout[3*OUT_W +: OUT_W];
  assign pixel_out4  = r_dout[4*OUT_W +: OUT_W];

endmodule
